// File: rtl/button_shaper_multi.sv
// button_shaper_multi: NUM_CH independent active-low pushbutton channels.
// Each channel has a two-flop synchroniser, a counter-based debounce FSM,
// a single-cycle press pulse and a debounced pressed level. any_pulse is the
// OR of all channel pulses, registered in the same cycle as pulse_out.
// Optional feature: define BUTTON_REPEAT_EN to add auto-repeat pulses while a
// button stays held (first after REPEAT_DELAY, then every REPEAT_PERIOD).
module button_shaper_multi #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] level_out,
    output logic              any_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRESS_DB = 3'd1,
        ST_FIRE     = 3'd2,
        ST_HELD     = 3'd3,
        ST_REL_DB   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;
    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] pulse_d;
    logic [NUM_CH-1:0] level_d;
    logic [NUM_CH-1:0] pulse_q;
    logic [NUM_CH-1:0] level_q;
    logic              any_q;

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DLY_LIM = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PER_LIM = CNT_W'(REPEAT_PERIOD);

    // Set once the first auto-repeat of the current hold has fired.
    logic [NUM_CH-1:0] rep_seen_q;
    logic [NUM_CH-1:0] rep_seen_d;

    // First-repeat flag register, one per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_seen_q <= {NUM_CH{1'b0}};
        end else begin
            rep_seen_q <= rep_seen_d;
        end
    end
`else
    // Repeat timing parameters have no effect without the repeat feature.
    logic unused_rep_s;
    assign unused_rep_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // Two-flop synchroniser; idles at released (1) so reset looks like no press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {NUM_CH{1'b1}};
            sync2_q <= {NUM_CH{1'b1}};
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= ST_IDLE;
                cnt_q[ch]   <= {CNT_W{1'b0}};
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
        end
    end

    // Next-state, counter and output decode for every channel.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            pulse_d[ch] = 1'b0;
            level_d[ch] = 1'b0;
`ifdef BUTTON_REPEAT_EN
            rep_seen_d[ch] = rep_seen_q[ch];
`endif
            case (state_q[ch])
                ST_IDLE: begin
                    if (!sync2_q[ch]) begin
                        state_d[ch] = ST_PRESS_DB;
                        cnt_d[ch]   = CNT_ONE;
                    end else begin
                        cnt_d[ch]   = {CNT_W{1'b0}};
                    end
                end
                ST_PRESS_DB: begin
                    if (sync2_q[ch]) begin
                        state_d[ch] = ST_IDLE;
                        cnt_d[ch]   = {CNT_W{1'b0}};
                    end else if (cnt_q[ch] >= DB_LIM - CNT_ONE) begin
                        // Saturate at the compare value; never wraps.
                        state_d[ch] = ST_FIRE;
                        cnt_d[ch]   = DB_LIM;
                    end else begin
                        cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                    end
                end
                ST_FIRE: begin
                    pulse_d[ch] = 1'b1;
                    level_d[ch] = 1'b1;
                    state_d[ch] = ST_HELD;
                    cnt_d[ch]   = {CNT_W{1'b0}};
`ifdef BUTTON_REPEAT_EN
                    rep_seen_d[ch] = 1'b0;
`endif
                end
                ST_HELD: begin
                    level_d[ch] = 1'b1;
                    if (sync2_q[ch]) begin
                        // Release wins over a coincident repeat.
                        state_d[ch] = ST_REL_DB;
                        cnt_d[ch]   = CNT_ONE;
                    end else begin
`ifdef BUTTON_REPEAT_EN
                        if (cnt_q[ch] >= (rep_seen_q[ch] ? REP_PER_LIM : REP_DLY_LIM)) begin
                            pulse_d[ch]    = 1'b1;
                            cnt_d[ch]      = {CNT_W{1'b0}};
                            rep_seen_d[ch] = 1'b1;
                        end else begin
                            cnt_d[ch]      = cnt_q[ch] + CNT_ONE;
                        end
`else
                        cnt_d[ch] = {CNT_W{1'b0}};
`endif
                    end
                end
                ST_REL_DB: begin
                    level_d[ch] = 1'b1;
                    if (!sync2_q[ch]) begin
                        // Bounce back to pressed: no new pulse.
                        state_d[ch] = ST_HELD;
                        cnt_d[ch]   = {CNT_W{1'b0}};
                    end else if (cnt_q[ch] >= DB_LIM - CNT_ONE) begin
                        state_d[ch] = ST_IDLE;
                        cnt_d[ch]   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d[ch]   = cnt_q[ch] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[ch] = ST_IDLE;
                    cnt_d[ch]   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered outputs decoded from the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= {NUM_CH{1'b0}};
            level_q <= {NUM_CH{1'b0}};
            any_q   <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            level_q <= level_d;
            any_q   <= |pulse_d;
        end
    end

    assign pulse_out = pulse_q;
    assign level_out = level_q;
    assign any_pulse = any_q;

endmodule

// File: tb/tb_button_shaper_multi.sv
// Self-checking bench for button_shaper_multi (NUM_CH=4, DEBOUNCE_CYCLES=4).
// Each scenario pushes per-cycle {raw stimulus, expected outputs} entries to a
// scoreboard queue, then pops them one per clock and compares the DUT outputs.
module tb_button_shaper_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw_in;
    logic [3:0] pulse_out;
    logic [3:0] level_out;
    logic       any_pulse;

    int checks;
    int errors;

    typedef struct packed {
        logic [3:0] raw;
        logic [3:0] pulse;
        logic [3:0] level;
        logic       any;
    } vec_t;

    vec_t sb_q[$];

    button_shaper_multi #(
        .NUM_CH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .raw_in(raw_in),
        .pulse_out(pulse_out),
        .level_out(level_out),
        .any_pulse(any_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive raw on the falling edge, return 1 time unit after the next rising edge.
    task automatic drive_cycle(input logic [3:0] r);
        @(negedge clk);
        raw_in = r;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [3:0] p, input logic [3:0] l);
        vec_t v;
        v.raw   = r;
        v.pulse = p;
        v.level = l;
        v.any   = |p;
        sb_q.push_back(v);
    endtask

    task automatic test_reset;
        vec_t v;
        int   n;
        rst_n  = 1'b1;
        raw_in = 4'hF;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (pulse_out !== 4'h0 || level_out !== 4'h0 || any_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got pulse=%b level=%b any=%b want 0", pulse_out, level_out, any_pulse);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) push(4'hF, 4'h0, 4'h0);
        n = 0;
        while (sb_q.size() > 0) begin
            v = sb_q.pop_front();
            drive_cycle(v.raw);
            checks++;
            if (pulse_out !== v.pulse || level_out !== v.level || any_pulse !== v.any) begin
                errors++;
                $display("FAIL reset_idle n=%0d got pulse=%b level=%b any=%b want pulse=%b level=%b any=%b",
                         n, pulse_out, level_out, any_pulse, v.pulse, v.level, v.any);
            end
            n++;
        end
    endtask

    task automatic test_single_press;
        vec_t       v;
        int         n;
        logic [3:0] p;
        for (int i = 0; i < 30; i++) begin
            p = (i == 6) ? 4'h1 : 4'h0;
`ifdef BUTTON_REPEAT_EN
            if (i == 17) p = 4'h1;
`endif
            push((i < 20) ? 4'hE : 4'hF, p, (i >= 6 && i < 26) ? 4'h1 : 4'h0);
        end
        n = 0;
        while (sb_q.size() > 0) begin
            v = sb_q.pop_front();
            drive_cycle(v.raw);
            checks++;
            if (pulse_out !== v.pulse || level_out !== v.level || any_pulse !== v.any) begin
                errors++;
                $display("FAIL single_press n=%0d got pulse=%b level=%b any=%b want pulse=%b level=%b any=%b",
                         n, pulse_out, level_out, any_pulse, v.pulse, v.level, v.any);
            end
            n++;
        end
    endtask

    task automatic test_bounce;
        vec_t v;
        int   n;
        logic b;
        for (int i = 0; i < 26; i++) begin
            b = (i < 20) ? (((i / 2) % 2) != 0) : 1'b1;
            push({2'b11, b, 1'b1}, 4'h0, 4'h0);
        end
        n = 0;
        while (sb_q.size() > 0) begin
            v = sb_q.pop_front();
            drive_cycle(v.raw);
            checks++;
            if (pulse_out !== v.pulse || level_out !== v.level || any_pulse !== v.any) begin
                errors++;
                $display("FAIL bounce n=%0d got pulse=%b level=%b any=%b want pulse=%b level=%b any=%b",
                         n, pulse_out, level_out, any_pulse, v.pulse, v.level, v.any);
            end
            n++;
        end
    endtask

    // Channels 2 and 3 pressed together; release contains a 2-cycle low glitch.
    task automatic test_simultaneous;
        vec_t v;
        int   n;
        logic low;
        for (int i = 0; i < 30; i++) begin
            low = (i < 15) || (i == 17) || (i == 18);
            push(low ? 4'h3 : 4'hF, (i == 6) ? 4'hC : 4'h0, (i >= 6 && i < 25) ? 4'hC : 4'h0);
        end
        n = 0;
        while (sb_q.size() > 0) begin
            v = sb_q.pop_front();
            drive_cycle(v.raw);
            checks++;
            if (pulse_out !== v.pulse || level_out !== v.level || any_pulse !== v.any) begin
                errors++;
                $display("FAIL simultaneous n=%0d got pulse=%b level=%b any=%b want pulse=%b level=%b any=%b",
                         n, pulse_out, level_out, any_pulse, v.pulse, v.level, v.any);
            end
            n++;
        end
    endtask

    // Reset in PRESS_DB (cnt=2) and in HELD, button held low throughout.
    task automatic test_reset_abort;
        vec_t v;
        int   n;
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 0) begin
                for (int i = 0; i < 4; i++) push(4'hE, 4'h0, 4'h0);
            end else if (phase == 1) begin
                for (int i = 0; i < 10; i++) push(4'hE, (i == 6) ? 4'h1 : 4'h0, (i >= 6) ? 4'h1 : 4'h0);
            end else begin
                for (int i = 0; i < 12; i++) push(4'hE, (i == 6) ? 4'h1 : 4'h0, (i >= 6) ? 4'h1 : 4'h0);
                for (int i = 0; i < 10; i++) push(4'hF, 4'h0, (i < 6) ? 4'h1 : 4'h0);
            end
            n = 0;
            while (sb_q.size() > 0) begin
                v = sb_q.pop_front();
                drive_cycle(v.raw);
                checks++;
                if (pulse_out !== v.pulse || level_out !== v.level || any_pulse !== v.any) begin
                    errors++;
                    $display("FAIL reset_abort p%0d n=%0d got pulse=%b level=%b any=%b want pulse=%b level=%b any=%b",
                             phase, n, pulse_out, level_out, any_pulse, v.pulse, v.level, v.any);
                end
                n++;
            end
            if (phase < 2) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (pulse_out !== 4'h0 || level_out !== 4'h0 || any_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_abort_async p%0d got pulse=%b level=%b any=%b want 0",
                             phase, pulse_out, level_out, any_pulse);
                end
                rst_n = 1'b1;
            end
        end
    endtask

`ifdef BUTTON_REPEAT_EN
    task automatic test_repeat;
        vec_t v;
        int   n;
        logic hit;
        for (int i = 0; i < 52; i++) begin
            hit = (i == 6) || (i == 17) || (i == 23) || (i == 29) || (i == 35) || (i == 41);
            push((i < 40) ? 4'hE : 4'hF, hit ? 4'h1 : 4'h0, (i >= 6 && i < 46) ? 4'h1 : 4'h0);
        end
        n = 0;
        while (sb_q.size() > 0) begin
            v = sb_q.pop_front();
            drive_cycle(v.raw);
            checks++;
            if (pulse_out !== v.pulse || level_out !== v.level || any_pulse !== v.any) begin
                errors++;
                $display("FAIL repeat n=%0d got pulse=%b level=%b any=%b want pulse=%b level=%b any=%b",
                         n, pulse_out, level_out, any_pulse, v.pulse, v.level, v.any);
            end
            n++;
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_reset_abort();
`ifdef BUTTON_REPEAT_EN
        test_repeat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
